// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: multi-channel arbiter onto one asynchronous SRAM port.
// Each granted access runs a fixed number of SRAM cycles, then acknowledges
// the winner for one cycle. Only channel 0 may win while initializing is high.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | strobes idle, arbitrate eligible requests on every edge
// ST_ACCESS | SRAM strobes active, counter runs down from ACCESS_CYCLES-1
// ST_DONE   | one-cycle ack to the winner, no arbitration
module ram_port_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int CHANNELS      = 3,
    parameter int ACCESS_CYCLES = 2,
    parameter int RR_MODE       = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           initializing,
    input  logic [CHANNELS-1:0]            req,
    input  logic [CHANNELS-1:0]            we,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_wdata,
    output logic [CHANNELS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           busy,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_wdata,
    input  logic [DATA_WIDTH-1:0]          ram_rdata,
    output logic                           ram_ce_n,
    output logic                           ram_oe_n,
    output logic                           ram_we_n
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CHANNELS-1:0]     ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;

    logic [CHANNELS-1:0]     elig;
    logic                    found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        win_next;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    int                      cand;

    // Winner search: candidates visited from ptr (round-robin) or from 0 (fixed).
    always_comb begin
        elig = req;
        if (initializing) begin
            elig = {{(CHANNELS-1){1'b0}}, req[0]};
        end
        found     = 1'b0;
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        cand      = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = (RR_MODE != 0) ? int'(ptr_q) + i : i;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            for (int j = 0; j < CHANNELS; j++) begin
                if (!found && (cand == j) && elig[j]) begin
                    found     = 1'b1;
                    win_idx   = IDX_W'(j);
                    win_we    = we[j];
                    win_addr  = ch_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                    win_wdata = ch_wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        win_next = (win_idx == IDX_W'(CHANNELS-1)) ? '0 : win_idx + IDX_W'(1);
    end

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_W'(ACCESS_CYCLES-1);
                    idx_d   = win_idx;
                    we_d    = win_we;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    if (!initializing) begin
                        ptr_d = win_next;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        ce_n_d = !(state_d == ST_ACCESS);
        oe_n_d = !((state_d == ST_ACCESS) && !we_d);
        // Write strobe releases in the last cycle so data is held past we_n rising.
        we_n_d = !((state_d == ST_ACCESS) && we_d && (cnt_d != '0));
        ack_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ack_d[i] = (state_d == ST_DONE) && (idx_d == IDX_W'(i));
        end
    end

    // State and output registers; reset drops the strobes without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_ce_n  = ce_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances run in lockstep, one round-robin
// with 2-cycle accesses and one fixed-priority with 3-cycle accesses.
module tb_ram_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int C   = 3;
    localparam int AC0 = 2;
    localparam int AC1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              initializing;
    logic [C-1:0]      we;
    logic [C*AW-1:0]   ch_addr;
    logic [C*DW-1:0]   ch_wdata;

    logic [C-1:0]      req_v       [2];
    logic [C-1:0]      ack_v       [2];
    logic [DW-1:0]     rdata_v     [2];
    logic              busy_v      [2];
    logic [AW-1:0]     ram_addr_v  [2];
    logic [DW-1:0]     ram_wdata_v [2];
    logic [DW-1:0]     ram_rdata_v [2];
    logic              ce_v        [2];
    logic              oe_v        [2];
    logic              wen_v       [2];

    function automatic logic [DW-1:0] sram(input logic [AW-1:0] a);
        return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h3C5A);
    endfunction

    assign ram_rdata_v[0] = sram(ram_addr_v[0]);
    assign ram_rdata_v[1] = sram(ram_addr_v[1]);

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(C),
                       .ACCESS_CYCLES(AC0), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .initializing(initializing),
        .req(req_v[0]), .we(we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ack(ack_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]),
        .ram_addr(ram_addr_v[0]), .ram_wdata(ram_wdata_v[0]), .ram_rdata(ram_rdata_v[0]),
        .ram_ce_n(ce_v[0]), .ram_oe_n(oe_v[0]), .ram_we_n(wen_v[0])
    );

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(C),
                       .ACCESS_CYCLES(AC1), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .initializing(initializing),
        .req(req_v[1]), .we(we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ack(ack_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]),
        .ram_addr(ram_addr_v[1]), .ram_wdata(ram_wdata_v[1]), .ram_rdata(ram_rdata_v[1]),
        .ram_ce_n(ce_v[1]), .ram_oe_n(oe_v[1]), .ram_we_n(wen_v[1])
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Model: phase 0 = idle, 1..AC = access cycle number, AC+1 = ack cycle.
    int            m_phase [2];
    int            m_win   [2];
    int            m_ptr   [2];
    logic          m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];

    int            step_cnt [2];
    int            ack_at   [2];
    int            ack_val  [2];
    int            n_oe     [2];
    int            n_we     [2];
    int            n_ce     [2];
    int            n_ack1   [2];
    logic [C-1:0]  prev_ack [2];
    bit            auto_on;
    int            obs0 [$];
    int            obs1 [$];

    function automatic int ac_of(input int k);
        return (k == 0) ? AC0 : AC1;
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0h, expected %0h", nm, k, act, exp);
    endtask

    task automatic model_reset(input int k);
        m_phase[k] = 0;
        m_win[k]   = 0;
        m_ptr[k]   = 0;
        m_we[k]    = 1'b0;
        m_addr[k]  = '0;
        m_wdata[k] = '0;
        m_rdata[k] = '0;
    endtask

    task automatic model_update(input int k);
        logic [C-1:0] el;
        int w;
        int ac;
        ac = ac_of(k);
        if (m_phase[k] == 0) begin
            el = initializing ? (req_v[k] & 3'b001) : req_v[k];
            if (el != '0) begin
                w = -1;
                for (int i = 0; i < C; i++) begin
                    int c;
                    c = (k == 0) ? (m_ptr[k] + i) % C : i;
                    if (w < 0 && ((int'(el) >> c) & 1) == 1) w = c;
                end
                m_win[k]   = w;
                m_addr[k]  = AW'(ch_addr >> (w*AW));
                m_wdata[k] = DW'(ch_wdata >> (w*DW));
                m_we[k]    = ((int'(we) >> w) & 1) == 1;
                if (!initializing) m_ptr[k] = (w + 1) % C;
                m_phase[k] = 1;
            end
        end else if (m_phase[k] < ac) begin
            m_phase[k]++;
        end else if (m_phase[k] == ac) begin
            if (!m_we[k]) m_rdata[k] = sram(m_addr[k]);
            m_phase[k] = ac + 1;
        end else begin
            m_phase[k] = 0;
        end
    endtask

    task automatic compare(input int k);
        int ac;
        bit acc;
        int ea;
        ac  = ac_of(k);
        acc = (m_phase[k] >= 1) && (m_phase[k] <= ac);
        ea  = (m_phase[k] == ac + 1) ? (1 << m_win[k]) : 0;
        chk("busy",      k, int'(busy_v[k]),      int'(m_phase[k] != 0));
        chk("ram_ce_n",  k, int'(ce_v[k]),        int'(!acc));
        chk("ram_oe_n",  k, int'(oe_v[k]),        int'(!(acc && !m_we[k])));
        chk("ram_we_n",  k, int'(wen_v[k]),       int'(!(acc && m_we[k] && m_phase[k] < ac)));
        chk("ack",       k, int'(ack_v[k]),       ea);
        chk("ram_addr",  k, int'(ram_addr_v[k]),  int'(m_addr[k]));
        chk("ram_wdata", k, int'(ram_wdata_v[k]), int'(m_wdata[k]));
        chk("rdata",     k, int'(rdata_v[k]),     int'(m_rdata[k]));
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            step_cnt[k] = 0;
            ack_at[k]   = -1;
            ack_val[k]  = 0;
            n_oe[k]     = 0;
            n_we[k]     = 0;
            n_ce[k]     = 0;
            n_ack1[k]   = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_update(0);
            model_update(1);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            compare(k);
            step_cnt[k]++;
            if (!oe_v[k])  n_oe[k]++;
            if (!wen_v[k]) n_we[k]++;
            if (!ce_v[k])  n_ce[k]++;
            if (ack_v[k] != '0) begin
                if (ack_at[k] < 0) begin
                    ack_at[k]  = step_cnt[k];
                    ack_val[k] = int'(ack_v[k]);
                end
                for (int c = 0; c < C; c++) begin
                    if (((int'(ack_v[k]) >> c) & 1) == 1) begin
                        if (k == 0) obs0.push_back(c);
                        else        obs1.push_back(c);
                        if (c == 1) n_ack1[k]++;
                    end
                end
            end
            if (auto_on) req_v[k] = 3'b111 & ~ack_v[k] & ~prev_ack[k];
            else         req_v[k] = req_v[k] & ~ack_v[k];
            prev_ack[k] = ack_v[k];
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while ((req_v[0] != '0 || req_v[1] != '0 || m_phase[0] != 0 || m_phase[1] != 0)
               && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", 0, int'(n < limit), 1);
    endtask

    task automatic wait_obs(input int cnt, input int limit);
        int n;
        n = 0;
        while ((obs0.size() < cnt || obs1.size() < cnt) && n < limit) begin
            step();
            n++;
        end
        chk("grant_timeout", 0, int'(n < limit), 1);
    endtask

    function automatic int obs_at(input int k, input int i);
        if (k == 0) return (i < obs0.size()) ? obs0[i] : -1;
        return (i < obs1.size()) ? obs1[i] : -1;
    endfunction

    int exp_rr [6] = '{0, 1, 2, 0, 1, 2};
    int exp_fp [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        initializing = 1'b0;
        we           = '0;
        ch_addr      = '0;
        ch_wdata     = '0;
        auto_on      = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_v[k]    = '0;
            prev_ack[k] = '0;
            model_reset(k);
        end
        clear_stats();
        #1 rst = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy",  k, int'(busy_v[k]), 0);
            chk("reset_ce_n",  k, int'(ce_v[k]), 1);
            chk("reset_we_n",  k, int'(wen_v[k]), 1);
            chk("reset_rdata", k, int'(rdata_v[k]), 0);
        end
        rst = 1'b1;
        step();

        // Read on ch1
        ch_addr = {16'h0300, 16'h1234, 16'h0100};
        we      = 3'b000;
        req_v[0] = 3'b010;
        req_v[1] = 3'b010;
        clear_stats();
        wait_done(30);
        for (int k = 0; k < 2; k++) begin
            chk("rd_ack_cycle", k, ack_at[k], (k == 0) ? 3 : 4);
            chk("rd_ack_val",   k, ack_val[k], 'b010);
            chk("rd_data",      k, int'(rdata_v[k]), 'hBEEF);
            chk("rd_oe_cycles", k, n_oe[k], (k == 0) ? 2 : 3);
            chk("model_rdata",  k, int'(m_rdata[k]), 'hBEEF);
        end

        // Write on ch2
        ch_addr  = {16'h0010, 16'h1234, 16'h0100};
        ch_wdata = {16'h5A5A, 16'h0000, 16'h0000};
        we       = 3'b100;
        req_v[0] = 3'b100;
        req_v[1] = 3'b100;
        clear_stats();
        wait_done(30);
        for (int k = 0; k < 2; k++) begin
            chk("wr_ack_val",   k, ack_val[k], 'b100);
            chk("wr_we_cycles", k, n_we[k], (k == 0) ? 1 : 2);
            chk("wr_ce_cycles", k, n_ce[k], (k == 0) ? 2 : 3);
            chk("wr_oe_cycles", k, n_oe[k], 0);
            chk("wr_addr_hold", k, int'(ram_addr_v[k]), 'h0010);
            chk("wr_data_hold", k, int'(ram_wdata_v[k]), 'h5A5A);
            chk("rdata_held",   k, int'(rdata_v[k]), 'hBEEF);
        end

        // Continuous demand: round-robin vs fixed priority grant order
        we      = 3'b000;
        ch_addr = {16'h0300, 16'h0200, 16'h0100};
        obs0.delete();
        obs1.delete();
        auto_on  = 1'b1;
        req_v[0] = 3'b111;
        req_v[1] = 3'b111;
        wait_obs(6, 80);
        auto_on  = 1'b0;
        req_v[0] = '0;
        req_v[1] = '0;
        wait_done(30);
        for (int i = 0; i < 6; i++) begin
            chk("rr_order", 0, obs_at(0, i), exp_rr[i]);
            chk("fp_order", 1, obs_at(1, i), exp_fp[i]);
        end

        // Reset in the middle of a write
        ch_addr  = {16'h0ABC, 16'h0200, 16'h0100};
        ch_wdata = {16'h1357, 16'h0000, 16'h0000};
        we       = 3'b100;
        req_v[0] = 3'b100;
        req_v[1] = 3'b100;
        obs0.delete();
        obs1.delete();
        step();
        for (int k = 0; k < 2; k++) begin
            chk("pre_rst_we_n", k, int'(wen_v[k]), 0);
            chk("pre_rst_ce_n", k, int'(ce_v[k]), 0);
        end
        rst = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_we_n", k, int'(wen_v[k]), 1);
            chk("async_rst_ce_n", k, int'(ce_v[k]), 1);
            chk("async_rst_busy", k, int'(busy_v[k]), 0);
            model_reset(k);
            req_v[k]    = '0;
            prev_ack[k] = '0;
        end
        we = 3'b000;
        step();
        step();
        rst = 1'b1;
        repeat (4) step();
        chk("no_ack_after_rst", 0, obs0.size(), 0);
        chk("no_ack_after_rst", 1, obs1.size(), 0);

        // initializing restricts grants to ch0
        initializing = 1'b1;
        ch_addr  = {16'h0300, 16'h0200, 16'h0100};
        req_v[0] = 3'b110;
        req_v[1] = 3'b110;
        repeat (4) step();
        for (int k = 0; k < 2; k++) chk("init_no_grant_busy", k, int'(busy_v[k]), 0);
        chk("init_no_ack", 0, obs0.size() + obs1.size(), 0);
        req_v[0] = 3'b111;
        req_v[1] = 3'b111;
        step();
        for (int k = 0; k < 2; k++) chk("init_grant_busy", k, int'(busy_v[k]), 1);
        initializing = 1'b0;
        wait_obs(2, 40);
        for (int k = 0; k < 2; k++) begin
            chk("init_first_ch0", k, obs_at(k, 0), 0);
            chk("init_next_ch1",  k, obs_at(k, 1), 1);
        end
        req_v[0] = '0;
        req_v[1] = '0;
        wait_done(40);

        // ch1 drops req during its access
        ch_addr  = {16'h0300, 16'h1234, 16'h0100};
        req_v[0] = 3'b010;
        req_v[1] = 3'b010;
        clear_stats();
        step();
        req_v[0] = '0;
        req_v[1] = '0;
        wait_done(30);
        for (int k = 0; k < 2; k++) begin
            chk("drop_ack_count", k, n_ack1[k], 1);
            chk("drop_ack_cycle", k, ack_at[k], (k == 0) ? 3 : 4);
            chk("drop_rdata",     k, int'(rdata_v[k]), 'hBEEF);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_tot);
        $fatal(1);
    end

endmodule
